// File: rtl/imm_operand_sequencer.sv
// Microcode sequencer for immediate-operand instructions (ALU A,d8 / LD r,d8 / LD rr,d16).
// Steps through one fetch M-cycle per immediate byte, then one execute M-cycle with an overlapped IR fetch.
module imm_operand_sequencer #(
  parameter int IMM_BYTES        = 1,
  parameter int STEPS_PER_MCYCLE = 4,
  parameter int ALU_CTRL_W       = 7
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_n,
  input  logic                  i_Start,
  input  logic                  i_Mode,
  input  logic [ALU_CTRL_W-1:0] i_ALU_Op,
  input  logic                  i_Wait,
  input  logic                  i_Flush,
  output logic                  o_Busy,
  output logic                  o_Address_Out,
  output logic                  o_Increment_PC,
  output logic                  o_Bus_In,
  output logic [1:0]            o_Latch,
  output logic                  o_Prep_Param,
  output logic [ALU_CTRL_W-1:0] o_ALU_Control,
  output logic                  o_Write_Dest,
  output logic                  o_IR_Fetch,
  output logic                  o_Done
);

  localparam int SW = $clog2(STEPS_PER_MCYCLE);
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS_PER_MCYCLE - 1);
  localparam logic          LAST_BYTE = 1'(IMM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, IMM, EXEC} state_t;

  state_t                state, nxt_state;
  logic [SW-1:0]         step, nxt_step;
  logic                  byte_idx, nxt_byte;
  logic                  mode_q, nxt_mode;
  logic [ALU_CTRL_W-1:0] op_q, nxt_op;

  logic                  nxt_busy, nxt_addr, nxt_inc, nxt_bus_in, nxt_prep, nxt_write, nxt_ir, nxt_done;
  logic [1:0]            nxt_latch;
  logic [ALU_CTRL_W-1:0] nxt_alu;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    nxt_state = state;
    nxt_step  = step;
    nxt_byte  = byte_idx;
    nxt_mode  = mode_q;
    nxt_op    = op_q;
    if (i_Flush) begin
      nxt_state = IDLE;
      nxt_step  = '0;
      nxt_byte  = 1'b0;
    end else begin
      unique case (state)
        IDLE: if (i_Start) begin
          nxt_state = IMM;
          nxt_step  = '0;
          nxt_byte  = 1'b0;
          nxt_mode  = i_Mode;
          nxt_op    = i_ALU_Op;
        end
        IMM: begin
          if (step == '0 && i_Wait) begin
            nxt_step = step;
          end else if (step == LAST_STEP) begin
            nxt_step = '0;
            if (byte_idx != LAST_BYTE) nxt_byte = byte_idx + 1'b1;
            else                       nxt_state = EXEC;
          end else begin
            nxt_step = step + 1'b1;
          end
        end
        EXEC: begin
          if (step == LAST_STEP) begin
            nxt_state = IDLE;
            nxt_step  = '0;
            nxt_byte  = 1'b0;
          end else begin
            nxt_step = step + 1'b1;
          end
        end
        default: begin
          nxt_state = IDLE;
          nxt_step  = '0;
          nxt_byte  = 1'b0;
        end
      endcase
    end
  end

  // Outputs are the Moore decode of the next state, registered so they line up with that state.
  always_comb begin
    nxt_busy   = (nxt_state != IDLE);
    nxt_addr   = 1'b0;
    nxt_inc    = 1'b0;
    nxt_bus_in = 1'b0;
    nxt_latch  = '0;
    nxt_prep   = 1'b0;
    nxt_alu    = '0;
    nxt_write  = 1'b0;
    nxt_ir     = 1'b0;
    nxt_done   = 1'b0;
    if (nxt_state == IMM) begin
      nxt_addr   = (nxt_step == SW'(0));
      nxt_inc    = (nxt_step == SW'(1));
      nxt_bus_in = (nxt_step == SW'(2));
      if (nxt_step == SW'(2)) nxt_latch[nxt_byte] = 1'b1;
    end else if (nxt_state == EXEC) begin
      nxt_ir   = 1'b1;
      nxt_prep = (nxt_step == SW'(0));
      if (nxt_step == SW'(1)) begin
        if (nxt_mode) nxt_write = 1'b1;
        else          nxt_alu   = nxt_op;
      end
      nxt_done = (nxt_step == LAST_STEP);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; every register here is reset,
  // so outputs drop to 0 the moment i_Reset_n falls, without waiting for a clock.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state          <= IDLE;
      step           <= '0;
      byte_idx       <= 1'b0;
      mode_q         <= 1'b0;
      op_q           <= '0;
      o_Busy         <= 1'b0;
      o_Address_Out  <= 1'b0;
      o_Increment_PC <= 1'b0;
      o_Bus_In       <= 1'b0;
      o_Latch        <= '0;
      o_Prep_Param   <= 1'b0;
      o_ALU_Control  <= '0;
      o_Write_Dest   <= 1'b0;
      o_IR_Fetch     <= 1'b0;
      o_Done         <= 1'b0;
    end else begin
      state          <= nxt_state;
      step           <= nxt_step;
      byte_idx       <= nxt_byte;
      mode_q         <= nxt_mode;
      op_q           <= nxt_op;
      o_Busy         <= nxt_busy;
      o_Address_Out  <= nxt_addr;
      o_Increment_PC <= nxt_inc;
      o_Bus_In       <= nxt_bus_in;
      o_Latch        <= nxt_latch;
      o_Prep_Param   <= nxt_prep;
      o_ALU_Control  <= nxt_alu;
      o_Write_Dest   <= nxt_write;
      o_IR_Fetch     <= nxt_ir;
      o_Done         <= nxt_done;
    end
  end

endmodule

// File: tb/tb_imm_operand_sequencer.sv
// Directed bench for imm_operand_sequencer: a d8 instance (defaults) and a d16 instance.
// Each table row drives one clock of inputs and gives the full output word expected after that edge.
module tb_imm_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b, mode, wt, fl;
  logic [6:0] op;

  logic       busy_a, addr_a, inc_a, bus_a, prep_a, wr_a, ir_a, done_a;
  logic [1:0] latch_a;
  logic [6:0] alu_a;
  logic       busy_b, addr_b, inc_b, bus_b, prep_b, wr_b, ir_b, done_b;
  logic [1:0] latch_b;
  logic [6:0] alu_b;

  always #5 clk = ~clk;

  imm_operand_sequencer dut_a (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Start(start_a), .i_Mode(mode), .i_ALU_Op(op),
    .i_Wait(wt), .i_Flush(fl), .o_Busy(busy_a), .o_Address_Out(addr_a), .o_Increment_PC(inc_a),
    .o_Bus_In(bus_a), .o_Latch(latch_a), .o_Prep_Param(prep_a), .o_ALU_Control(alu_a),
    .o_Write_Dest(wr_a), .o_IR_Fetch(ir_a), .o_Done(done_a)
  );

  imm_operand_sequencer #(.IMM_BYTES(2)) dut_b (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Start(start_b), .i_Mode(mode), .i_ALU_Op(op),
    .i_Wait(wt), .i_Flush(fl), .o_Busy(busy_b), .o_Address_Out(addr_b), .o_Increment_PC(inc_b),
    .o_Bus_In(bus_b), .o_Latch(latch_b), .o_Prep_Param(prep_b), .o_ALU_Control(alu_b),
    .o_Write_Dest(wr_b), .o_IR_Fetch(ir_b), .o_Done(done_b)
  );

  // Output word layout: {busy, addr, inc, bus_in, latch[1:0], prep, alu[6:0], write, ir, done}
  wire [16:0] out_a = {busy_a, addr_a, inc_a, bus_a, latch_a, prep_a, alu_a, wr_a, ir_a, done_a};
  wire [16:0] out_b = {busy_b, addr_b, inc_b, bus_b, latch_b, prep_b, alu_b, wr_b, ir_b, done_b};

  typedef struct {
    string      name;
    logic       sel;
    logic       st, md, w, f;
    logic [6:0] op;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [16:0] ex(input logic b, a, i, bi, input logic [1:0] l,
                                      input logic p, input logic [6:0] alu, input logic w, ir, d);
    return {b, a, i, bi, l, p, alu, w, ir, d};
  endfunction

  task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %05h expected %05h", name, got, exp);
  endtask

  task automatic add(input string name, input logic sel, st, md, w, f,
                     input logic [6:0] o, input logic [16:0] e);
    vec_t v;
    v.name = name; v.sel = sel; v.st = st; v.md = md; v.w = w; v.f = f; v.op = o; v.exp = e;
    tbl.push_back(v);
  endtask

  // Common words for a d8 run in mode 0 with latched op x.
  function automatic logic [16:0] w_addr();  return ex(1,1,0,0,2'b00,0,7'h0,0,0,0); endfunction
  function automatic logic [16:0] w_inc();   return ex(1,0,1,0,2'b00,0,7'h0,0,0,0); endfunction
  function automatic logic [16:0] w_lat(input logic [1:0] l); return ex(1,0,0,1,l,0,7'h0,0,0,0); endfunction
  function automatic logic [16:0] w_idle();  return ex(1,0,0,0,2'b00,0,7'h0,0,0,0); endfunction
  function automatic logic [16:0] w_prep();  return ex(1,0,0,0,2'b00,1,7'h0,0,1,0); endfunction
  function automatic logic [16:0] w_alu(input logic [6:0] x); return ex(1,0,0,0,2'b00,0,x,0,1,0); endfunction
  function automatic logic [16:0] w_wr();    return ex(1,0,0,0,2'b00,0,7'h0,1,1,0); endfunction
  function automatic logic [16:0] w_ir();    return ex(1,0,0,0,2'b00,0,7'h0,0,1,0); endfunction
  function automatic logic [16:0] w_done();  return ex(1,0,0,0,2'b00,0,7'h0,0,1,1); endfunction

  initial begin
    rst_n = 1'b0; start_a = 0; start_b = 0; mode = 0; wt = 0; fl = 0; op = '0;

    // d8, mode 0, op 41: 8 busy cycles, Done on c8, Busy low on c9
    add("t1_c1_addr", 0, 1,0,0,0, 7'h41, w_addr());
    add("t1_c2_inc",  0, 0,0,0,0, 7'h41, w_inc());
    add("t1_c3_lat",  0, 0,0,0,0, 7'h41, w_lat(2'b01));
    add("t1_c4_idle", 0, 0,0,0,0, 7'h41, w_idle());
    add("t1_c5_prep", 0, 0,0,0,0, 7'h41, w_prep());
    add("t1_c6_alu",  0, 0,0,0,0, 7'h41, w_alu(7'h41));
    add("t1_c7_ir",   0, 0,0,0,0, 7'h41, w_ir());
    add("t1_c8_done", 0, 0,0,0,0, 7'h41, w_done());
    add("t1_c9_free", 0, 0,0,0,0, 7'h41, '0);
    // Wait held 3 cycles in step 0: Address_Out for 4 cycles, Done slips by 3; Wait elsewhere ignored
    add("t3_addr0",   0, 1,0,0,0, 7'h0a, w_addr());
    add("t3_addr1",   0, 0,0,1,0, 7'h0a, w_addr());
    add("t3_addr2",   0, 0,0,1,0, 7'h0a, w_addr());
    add("t3_addr3",   0, 0,0,1,0, 7'h0a, w_addr());
    add("t3_inc",     0, 0,0,0,0, 7'h0a, w_inc());
    add("t3_lat",     0, 0,0,1,0, 7'h0a, w_lat(2'b01));
    add("t3_idle",    0, 0,0,1,0, 7'h0a, w_idle());
    add("t3_prep",    0, 0,0,1,0, 7'h0a, w_prep());
    add("t3_alu",     0, 0,0,1,0, 7'h0a, w_alu(7'h0a));
    add("t3_ir",      0, 0,0,0,0, 7'h0a, w_ir());
    add("t3_done",    0, 0,0,0,0, 7'h0a, w_done());
    add("t3_free",    0, 0,0,0,0, 7'h0a, '0);
    // Flush at EXEC step 1, then a normal start (mode 1) the next cycle
    add("t4_addr",    0, 1,0,0,0, 7'h15, w_addr());
    add("t4_inc",     0, 0,0,0,0, 7'h15, w_inc());
    add("t4_lat",     0, 0,0,0,0, 7'h15, w_lat(2'b01));
    add("t4_idle",    0, 0,0,0,0, 7'h15, w_idle());
    add("t4_prep",    0, 0,0,0,0, 7'h15, w_prep());
    add("t4_alu",     0, 0,0,0,0, 7'h15, w_alu(7'h15));
    add("t4_flushed", 0, 0,0,0,1, 7'h15, '0);
    add("t4_restart", 0, 1,1,0,0, 7'h33, w_addr());
    add("t4_inc2",    0, 0,0,0,0, 7'h15, w_inc());
    add("t4_lat2",    0, 0,0,0,0, 7'h15, w_lat(2'b01));
    add("t4_idle2",   0, 0,0,0,0, 7'h15, w_idle());
    add("t4_prep2",   0, 0,0,0,0, 7'h15, w_prep());
    add("t4_write2",  0, 0,0,0,0, 7'h15, w_wr());
    add("t4_ir2",     0, 0,0,0,0, 7'h15, w_ir());
    add("t4_done2",   0, 0,0,0,0, 7'h15, w_done());
    add("t4_free2",   0, 0,0,0,0, 7'h15, '0);
    add("flush_beats_start", 0, 1,0,0,1, 7'h15, '0);
    // Start held high: back-to-back runs, op changes while busy are not picked up
    add("t5_addr",    0, 1,0,0,0, 7'h22, w_addr());
    add("t5_inc",     0, 1,0,0,0, 7'h7f, w_inc());
    add("t5_lat",     0, 1,0,0,0, 7'h7f, w_lat(2'b01));
    add("t5_idle",    0, 1,0,0,0, 7'h7f, w_idle());
    add("t5_prep",    0, 1,0,0,0, 7'h7f, w_prep());
    add("t5_alu",     0, 1,0,0,0, 7'h7f, w_alu(7'h22));
    add("t5_ir",      0, 1,0,0,0, 7'h7f, w_ir());
    add("t5_done",    0, 1,0,0,0, 7'h7f, w_done());
    add("t5_gap",     0, 1,0,0,0, 7'h5a, '0);
    add("t5_addr2",   0, 1,0,0,0, 7'h5a, w_addr());
    add("t5_inc2",    0, 1,0,0,0, 7'h11, w_inc());
    add("t5_lat2",    0, 0,0,0,0, 7'h11, w_lat(2'b01));
    add("t5_idle2",   0, 0,0,0,0, 7'h11, w_idle());
    add("t5_prep2",   0, 0,0,0,0, 7'h11, w_prep());
    add("t5_alu2",    0, 0,0,0,0, 7'h11, w_alu(7'h5a));
    add("t5_ir2",     0, 0,0,0,0, 7'h11, w_ir());
    add("t5_done2",   0, 0,0,0,0, 7'h11, w_done());
    add("t5_free2",   0, 0,0,0,0, 7'h11, '0);
    // d16, mode 1: 12 busy cycles, both latch bits, Write_Dest on c10, ALU_Control stays 0
    add("t2_c1_addr", 1, 1,1,0,0, 7'h41, w_addr());
    add("t2_c2_inc",  1, 0,0,0,0, 7'h41, w_inc());
    add("t2_c3_lat0", 1, 0,0,0,0, 7'h41, w_lat(2'b01));
    add("t2_c4_idle", 1, 0,0,0,0, 7'h41, w_idle());
    add("t2_c5_addr", 1, 0,0,0,0, 7'h41, w_addr());
    add("t2_c6_inc",  1, 0,0,0,0, 7'h41, w_inc());
    add("t2_c7_lat1", 1, 0,0,0,0, 7'h41, w_lat(2'b10));
    add("t2_c8_idle", 1, 0,0,0,0, 7'h41, w_idle());
    add("t2_c9_prep", 1, 0,0,0,0, 7'h41, w_prep());
    add("t2_c10_wr",  1, 0,0,0,0, 7'h41, w_wr());
    add("t2_c11_ir",  1, 0,0,0,0, 7'h41, w_ir());
    add("t2_c12_done",1, 0,0,0,0, 7'h41, w_done());
    add("t2_c13_free",1, 0,0,0,0, 7'h41, '0);

    #12;
    check("reset_a", out_a, '0);
    check("reset_b", out_b, '0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      @(negedge clk);
      start_a = tbl[k].sel ? 1'b0 : tbl[k].st;
      start_b = tbl[k].sel ? tbl[k].st : 1'b0;
      mode    = tbl[k].md;
      wt      = tbl[k].w;
      fl      = tbl[k].f;
      op      = tbl[k].op;
      @(posedge clk);
      #1;
      check(tbl[k].name, tbl[k].sel ? out_b : out_a, tbl[k].exp);
    end

    // Async reset mid-IMM: outputs clear with no clock edge, then stay idle without a new start
    @(negedge clk);
    start_a = 1'b1; mode = 1'b0; wt = 1'b0; fl = 1'b0; op = 7'h41;
    @(posedge clk); #1;
    check("t6_addr", out_a, w_addr());
    @(negedge clk);
    start_a = 1'b0;
    @(posedge clk); #1;
    check("t6_inc", out_a, w_inc());
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_clear", out_a, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("t6_stay_idle", out_a, '0);
    end
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk); #1;
    check("t6_fresh_start", out_a, w_addr());
    start_a = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
